pdp8_timing_seq: RTL and testbench

// Major-cycle timing sequencer for the PDP-8/I core. It replaces the delay-line
// and one-shot chain with a single counter-driven FSM. It steps time states
// TS1..TS4, and emits one timing pulse TP1..TP4 at the end of each time state.
// It also owns the RUN flip-flop, stop/single-step handling, and the TS3 pause

---
 rtl/pdp8_timing_seq_if.sv | 22 ++
 rtl/pdp8_timing_seq.sv | 140 ++++++++++++++
 tb/tb_pdp8_timing_seq.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdp8_timing_seq_if.sv
// Front-panel keys, device handshake and timing outputs of the PDP-8/I major-cycle sequencer.
// The master side drives the keys and pause; the sequencer is the slave.
interface pdp8_timing_seq_if;
    logic       key_start;
    logic       key_stop;
    logic       single_step;
    logic       pause;
    logic       run;
    logic [3:0] ts;
    logic [3:0] tp;
    logic       cycle_done;

    modport master (
        output key_start, key_stop, single_step, pause,
        input  run, ts, tp, cycle_done
    );

    modport slave (
        input  key_start, key_stop, single_step, pause,
        output run, ts, tp, cycle_done
    );
endinterface

// File: rtl/pdp8_timing_seq.sv
// PDP-8/I major-cycle timing sequencer: steps TS1..TS4 with a TPn pulse closing each
// time state, and owns the RUN flip-flop, stop/single-step and the TS3 device pause.
//
// state | meaning
// IDLE  | halted, run=0, no time state
// S1    | TS1 body
// P1    | TS1 with TP1 asserted
// S2    | TS2 body
// P2    | TS2 with TP2 asserted
// S3    | TS3 body; held at its end while pause is high
// P3    | TS3 with TP3 asserted
// S4    | TS4 body
// P4    | TS4 with TP4 asserted; decides halt or next cycle
module pdp8_timing_seq #(
    parameter int CW        = 16,
    parameter int TS1_COUNT = 25,
    parameter int TS2_COUNT = 25,
    parameter int TS3_COUNT = 25,
    parameter int TS4_COUNT = 35,
    parameter int TP_WIDTH  = 10
) (
    input  logic              clk,
    input  logic              rst,
    pdp8_timing_seq_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        S1   = 4'd1,
        P1   = 4'd2,
        S2   = 4'd3,
        P2   = 4'd4,
        S3   = 4'd5,
        P3   = 4'd6,
        S4   = 4'd7,
        P4   = 4'd8
    } state_t;

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] TS1_C = CW'(TS1_COUNT);
    localparam logic [CW-1:0] TS2_C = CW'(TS2_COUNT);
    localparam logic [CW-1:0] TS3_C = CW'(TS3_COUNT);
    localparam logic [CW-1:0] TS4_C = CW'(TS4_COUNT);
    localparam logic [CW-1:0] TPW_C = CW'(TP_WIDTH);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          stop_pend, stop_pend_nx;

    logic          run_d;
    logic [3:0]    ts_d;
    logic [3:0]    tp_d;
    logic          cycle_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= ONE;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            stop_pend <= stop_pend_nx;
        end
    end

    // cnt counts 1..N within each state, so an N-count state lasts exactly N clocks.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + ONE;
        unique case (state)
            IDLE: begin
                cnt_nx = ONE;
                if (bus.key_start) state_nx = S1;
            end
            S1: if (cnt == TS1_C) begin state_nx = P1; cnt_nx = ONE; end
            P1: if (cnt == TPW_C) begin state_nx = S2; cnt_nx = ONE; end
            S2: if (cnt == TS2_C) begin state_nx = P2; cnt_nx = ONE; end
            P2: if (cnt == TPW_C) begin state_nx = S3; cnt_nx = ONE; end
            S3: begin
                if (cnt == TS3_C) begin
                    if (bus.pause) begin
                        cnt_nx = cnt;
                    end else begin
                        state_nx = P3;
                        cnt_nx   = ONE;
                    end
                end
            end
            P3: if (cnt == TPW_C) begin state_nx = S4; cnt_nx = ONE; end
            S4: if (cnt == TS4_C) begin state_nx = P4; cnt_nx = ONE; end
            P4: begin
                if (cnt == TPW_C) begin
                    cnt_nx   = ONE;
                    state_nx = (stop_pend || bus.single_step) ? IDLE : S1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = ONE;
            end
        endcase
    end

    // A stop in IDLE only sticks if a start moves us out of IDLE on the same edge.
    always_comb begin
        stop_pend_nx = stop_pend;
        if (state_nx == IDLE)  stop_pend_nx = 1'b0;
        else if (bus.key_stop) stop_pend_nx = 1'b1;
    end

    always_comb begin
        run_d        = (state != IDLE);
        ts_d         = 4'b0000;
        tp_d         = 4'b0000;
        cycle_done_d = 1'b0;
        unique case (state)
            IDLE: ;
            S1:   ts_d = 4'b0001;
            P1:   begin ts_d = 4'b0001; tp_d = 4'b0001; end
            S2:   ts_d = 4'b0010;
            P2:   begin ts_d = 4'b0010; tp_d = 4'b0010; end
            S3:   ts_d = 4'b0100;
            P3:   begin ts_d = 4'b0100; tp_d = 4'b0100; end
            S4:   ts_d = 4'b1000;
            P4:   begin
                ts_d         = 4'b1000;
                tp_d         = 4'b1000;
                cycle_done_d = (cnt == TPW_C);
            end
            default: run_d = 1'b0;
        endcase
    end

    assign bus.run        = run_d;
    assign bus.ts         = ts_d;
    assign bus.tp         = tp_d;
    assign bus.cycle_done = cycle_done_d;

endmodule

// File: tb/tb_pdp8_timing_seq.sv
// Directed bench for pdp8_timing_seq with default timing (150-clk cycle).
// Offset n means "sampled 1 ns after edge E0+n", where E0 is the edge that samples key_start.
module tb_pdp8_timing_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pdp8_timing_seq_if bus ();

    pdp8_timing_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
    endtask

    // Expected outputs at offset n; x is the extra TS3 length caused by pause.
    function automatic logic [3:0] exp_ts(int n, int x);
        if (n < 35)          return 4'b0001;
        else if (n < 70)     return 4'b0010;
        else if (n < 105 + x) return 4'b0100;
        else if (n < 150 + x) return 4'b1000;
        else                 return 4'b0000;
    endfunction

    function automatic logic [3:0] exp_tp(int n, int x);
        if (n >= 25 && n <= 34)                 return 4'b0001;
        else if (n >= 60 && n <= 69)            return 4'b0010;
        else if (n >= 95 + x && n <= 104 + x)   return 4'b0100;
        else if (n >= 140 + x && n <= 149 + x)  return 4'b1000;
        else                                    return 4'b0000;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({bus.run, bus.ts, bus.tp, bus.cycle_done} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state: got run=%b ts=%b tp=%b done=%b, want all 0",
                     bus.run, bus.ts, bus.tp, bus.cycle_done);
        end
        rst = 1'b0;
        tick();
        press_start();
        repeat (65) tick();
        n_checks++;
        if (bus.tp !== 4'b0010 || bus.run !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_p2: got run=%b tp=%b, want run=1 tp=0010", bus.run, bus.tp);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.run, bus.ts, bus.tp, bus.cycle_done} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_mid_p2: got run=%b ts=%b tp=%b done=%b, want all 0",
                     bus.run, bus.ts, bus.tp, bus.cycle_done);
        end
        tick();
        rst = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (bus.run !== 1'b0 || bus.ts !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_no_resume: got run=%b ts=%b, want run=0 ts=0000", bus.run, bus.ts);
        end
        bus.key_stop = 1'b1;
        tick();
        bus.key_stop = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus.run !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_stop_only: got run=%b, want 0", bus.run);
        end
    endtask

    // Also shows the stop pressed in IDLE earlier left no pending stop behind.
    task automatic test_free_run();
        int   rises[$];
        logic prev_tp0;
        int   idle_at;
        bit   ts_gap;
        press_start();
        prev_tp0 = 1'b0;
        ts_gap   = 1'b0;
        for (int n = 0; n < 450; n++) begin
            if (bus.ts === 4'b0000) ts_gap = 1'b1;
            if (bus.tp[0] === 1'b1 && prev_tp0 === 1'b0) rises.push_back(n);
            prev_tp0 = bus.tp[0];
            tick();
        end
        n_checks++;
        if (ts_gap) begin
            n_fail++;
            $display("FAIL free_run_ts_gap: got ts=0000 during run, want never 0");
        end
        n_checks++;
        if (rises.size() != 3) begin
            n_fail++;
            $display("FAIL free_run_rises: got %0d TP1 rises, want 3", rises.size());
        end else begin
            n_checks++;
            if (rises[0] != 25 || rises[1] != 175 || rises[2] != 325) begin
                n_fail++;
                $display("FAIL free_run_spacing: got TP1 rises at %0d %0d %0d, want 25 175 325",
                         rises[0], rises[1], rises[2]);
            end
        end
        // now at offset 450: key_stop sampled at edge 451, current cycle ends at 600
        bus.key_stop = 1'b1;
        tick();
        bus.key_stop = 1'b0;
        idle_at = -1;
        for (int n = 451; n < 700; n++) begin
            if (bus.run === 1'b0) begin
                idle_at = n;
                break;
            end
            tick();
        end
        n_checks++;
        if (idle_at != 600) begin
            n_fail++;
            $display("FAIL free_run_stop: got run fall at offset %0d, want 600 (-1 = timeout)", idle_at);
        end
    endtask

    task automatic test_basic_cycle();
        int bad_ts, bad_tp, bad_done, bad_run;
        bad_ts = 0; bad_tp = 0; bad_done = 0; bad_run = 0;
        press_start();
        for (int n = 0; n < 150; n++) begin
            if (bus.ts !== exp_ts(n, 0)) begin
                if (bad_ts == 0) $display("FAIL cycle_ts @%0d: got %b, want %b", n, bus.ts, exp_ts(n, 0));
                bad_ts++;
            end
            if (bus.tp !== exp_tp(n, 0)) begin
                if (bad_tp == 0) $display("FAIL cycle_tp @%0d: got %b, want %b", n, bus.tp, exp_tp(n, 0));
                bad_tp++;
            end
            if (bus.cycle_done !== (n == 149)) begin
                if (bad_done == 0) $display("FAIL cycle_done @%0d: got %b, want %b", n, bus.cycle_done, (n == 149));
                bad_done++;
            end
            if (bus.run !== 1'b1) bad_run++;
            bus.key_stop = (n == 40);
            tick();
        end
        bus.key_stop = 1'b0;
        n_checks += 4;
        if (bad_ts != 0)   n_fail++;
        if (bad_tp != 0)   n_fail++;
        if (bad_done != 0) n_fail++;
        if (bad_run != 0) begin
            n_fail++;
            $display("FAIL cycle_run: got run=0 in %0d clks of the cycle, want 0 clks", bad_run);
        end
        n_checks++;
        if (bus.run !== 1'b0 || bus.ts !== 4'b0000 || bus.tp !== 4'b0000) begin
            n_fail++;
            $display("FAIL cycle_stop_end: got run=%b ts=%b tp=%b at 150, want 0/0000/0000",
                     bus.run, bus.ts, bus.tp);
        end
    endtask

    task automatic test_single_step();
        bus.single_step = 1'b1;
        for (int k = 0; k < 2; k++) begin
            press_start();
            repeat (149) tick();
            n_checks++;
            if (bus.run !== 1'b1 || bus.cycle_done !== 1'b1) begin
                n_fail++;
                $display("FAIL step%0d_done: got run=%b done=%b at 149, want 1/1", k, bus.run, bus.cycle_done);
            end
            tick();
            n_checks++;
            if (bus.run !== 1'b0 || bus.ts !== 4'b0000) begin
                n_fail++;
                $display("FAIL step%0d_halt: got run=%b ts=%b at 150, want 0/0000", k, bus.run, bus.ts);
            end
            tick();
        end
        bus.single_step = 1'b0;
    endtask

    task automatic test_pause();
        int bad_ts, bad_tp, bad_done;
        bad_ts = 0; bad_tp = 0; bad_done = 0;
        press_start();
        for (int n = 0; n < 165; n++) begin
            if (bus.ts !== exp_ts(n, 15)) begin
                if (bad_ts == 0) $display("FAIL pause_ts @%0d: got %b, want %b", n, bus.ts, exp_ts(n, 15));
                bad_ts++;
            end
            if (bus.tp !== exp_tp(n, 15)) begin
                if (bad_tp == 0) $display("FAIL pause_tp @%0d: got %b, want %b", n, bus.tp, exp_tp(n, 15));
                bad_tp++;
            end
            if (bus.cycle_done !== (n == 164)) begin
                if (bad_done == 0) $display("FAIL pause_done @%0d: got %b, want %b", n, bus.cycle_done, (n == 164));
                bad_done++;
            end
            bus.key_stop = (n == 10);
            bus.pause    = (n >= 69 && n < 109);
            tick();
        end
        bus.key_stop = 1'b0;
        bus.pause    = 1'b0;
        n_checks += 3;
        if (bad_ts != 0)   n_fail++;
        if (bad_tp != 0)   n_fail++;
        if (bad_done != 0) n_fail++;
        n_checks++;
        if (bus.run !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_stop_end: got run=%b at 165, want 0", bus.run);
        end
    endtask

    task automatic test_start_stop_same();
        int   tp0_rises;
        logic prev_tp0;
        bit   run_low;
        bus.key_start = 1'b1;
        bus.key_stop  = 1'b1;
        tick();
        bus.key_start = 1'b0;
        bus.key_stop  = 1'b0;
        tp0_rises = 0;
        prev_tp0  = 1'b0;
        run_low   = 1'b0;
        for (int n = 0; n < 150; n++) begin
            if (bus.run !== 1'b1) run_low = 1'b1;
            if (bus.tp[0] === 1'b1 && prev_tp0 === 1'b0) begin
                tp0_rises++;
                n_checks++;
                if (n != 25) begin
                    n_fail++;
                    $display("FAIL same_clk_tp1_at: got TP1 rise at %0d, want 25", n);
                end
            end
            prev_tp0 = bus.tp[0];
            bus.key_start = (n == 50);
            tick();
        end
        bus.key_start = 1'b0;
        n_checks++;
        if (run_low || tp0_rises != 1) begin
            n_fail++;
            $display("FAIL same_clk_cycle: got run_low=%0b tp1_rises=%0d, want 0/1", run_low, tp0_rises);
        end
        n_checks++;
        if (bus.run !== 1'b0 || bus.ts !== 4'b0000) begin
            n_fail++;
            $display("FAIL same_clk_end: got run=%b ts=%b at 150, want 0/0000", bus.run, bus.ts);
        end
        repeat (20) tick();
        n_checks++;
        if (bus.run !== 1'b0) begin
            n_fail++;
            $display("FAIL same_clk_no_restart: got run=%b, want 0", bus.run);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.key_start   = 1'b0;
        bus.key_stop    = 1'b0;
        bus.single_step = 1'b0;
        bus.pause       = 1'b0;
        test_reset();
        test_free_run();
        test_basic_cycle();
        test_single_step();
        test_pause();
        test_start_stop_same();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
